// File: rtl/freq_meter.sv
//------------------------------------------------------------------------------
// freq_meter : counts rising edges of an asynchronous pulse train over a fixed
//              gate window of system clocks; one-cycle valid strobe per result.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic             valid,
   output logic [CNT_W-1:0] edge_count,
   output logic             overflow
);

   localparam int            GW        = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [GW-1:0]          gate_q, gate_d;
   logic [CNT_W-1:0]       acc_q, acc_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q, valid_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   of_q, of_d;

   logic                   sync_out;
   logic                   rise;
   logic                   acc_max;
   logic [CNT_W-1:0]       acc_next;
   logic                   ovf_next;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;

   // Saturating accumulate: once at all-ones the count sticks and the
   // overflow flag records that an edge was lost.
   assign acc_max  = &acc_q;
   assign acc_next = acc_max ? acc_q : acc_q + CNT_W'(rise);
   assign ovf_next = ovf_q | (acc_max & rise);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q  <= sync_out;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gate_q  <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         of_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         of_q    <= of_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gate_d  = gate_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      of_d    = of_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MEASURE;
               gate_d  = GATE_LAST;
               acc_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         MEASURE: begin
            acc_d = acc_next;
            ovf_d = ovf_next;
            if (gate_q != '0) begin
               gate_d = gate_q - GW'(1);
            end else begin
               // Last sample of the window is folded straight into the result,
               // and the next window (if any) starts on the very next cycle.
               cnt_d   = acc_next;
               of_d    = ovf_next;
               valid_d = 1'b1;
               gate_d  = GATE_LAST;
               acc_d   = '0;
               ovf_d   = 1'b0;
               if (!continuous) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q == MEASURE);
   assign valid      = valid_q;
   assign edge_count = cnt_q;
   assign overflow   = of_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// Randomized scoreboard bench for freq_meter: two instances (32-bit and 4-bit
// counters) share stimulus and are checked against a history-based model.
`timescale 1ns/1ps
`default_nettype none

module tb_freq_meter;

   localparam int GATE = 100;

   logic        clock      = 1'b0;
   logic        reset      = 1'b1;
   logic        sig_in     = 1'b0;
   logic        start      = 1'b0;
   logic        continuous = 1'b0;

   logic        busy32, valid32, ovf32;
   logic [31:0] cnt32;
   logic        busy4, valid4, ovf4;
   logic [3:0]  cnt4;

   always #5 clock = ~clock;

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut32 (
      .clock(clock), .reset(reset), .sig_in(sig_in), .start(start),
      .continuous(continuous), .busy(busy32), .valid(valid32),
      .edge_count(cnt32), .overflow(ovf32));

   freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
      .clock(clock), .reset(reset), .sig_in(sig_in), .start(start),
      .continuous(continuous), .busy(busy4), .valid(valid4),
      .edge_count(cnt4), .overflow(ovf4));

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- signal generator ----------------
   int gen_mode   = 1;   // 0 constant level, 1 square wave, 2 random
   bit gen_level  = 1'b0;
   int gen_period = 2;
   int gen_phase  = 0;
   int gcnt       = 0;

   initial begin
      forever begin
         @(negedge clock);
         gcnt++;
         case (gen_mode)
            0:       sig_in = gen_level;
            1:       sig_in = (((gcnt + gen_phase) % gen_period) < (gen_period / 2));
            default: sig_in = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- reference model ----------------
   // Window opened at edge S samples the synchronized rises at edges S+1..S+GATE;
   // a rise seen at edge n is the 0->1 step of sig_in captured at edges n-3, n-2.
   typedef struct {
      int     cyc;
      longint cnt;
   } exp_t;

   bit     hist [65536];
   int     cyc     = 0;
   bit     m_open  = 1'b0;
   int     m_start = 0;
   longint m_cnt;
   exp_t   exp_q [$];
   int     rd [2];

   function automatic bit rise_at(input int n);
      if (n < 3) return 1'b0;
      return hist[n-2] & ~hist[n-3];
   endfunction

   always @(posedge clock) begin
      cyc++;
      hist[cyc] = reset ? 1'b0 : sig_in;
      if (reset) begin
         m_open = 1'b0;
      end else if (m_open) begin
         if (cyc == m_start + GATE) begin
            m_cnt = 0;
            for (int k = m_start + 1; k <= cyc; k++) m_cnt += longint'(rise_at(k));
            exp_q.push_back('{cyc, m_cnt});
            if (continuous) m_start = cyc;
            else            m_open  = 1'b0;
         end
      end else if (start) begin
         m_open  = 1'b1;
         m_start = cyc;
      end
   end

   // ---------------- monitor ----------------
   task automatic check_out(input int id, input logic v, input longint cnt,
                            input logic ov, input logic bz, input int w);
      longint mx;
      longint ec;
      bit     eo;
      mx = (longint'(1) << w) - 1;
      n_checks++;
      if (bz !== m_open) begin
         n_fail++;
         $display("FAIL busy[w=%0d] cyc=%0d: got %b expected %b", w, cyc, bz, m_open);
      end
      if (v === 1'b1) begin
         if (rd[id] < exp_q.size() && exp_q[rd[id]].cyc == cyc) begin
            ec = (exp_q[rd[id]].cnt > mx) ? mx : exp_q[rd[id]].cnt;
            eo = (exp_q[rd[id]].cnt > mx);
            n_checks += 2;
            if (cnt !== ec) begin
               n_fail++;
               $display("FAIL edge_count[w=%0d] cyc=%0d: got %0d expected %0d", w, cyc, cnt, ec);
            end
            if (ov !== eo) begin
               n_fail++;
               $display("FAIL overflow[w=%0d] cyc=%0d: got %b expected %b", w, cyc, ov, eo);
            end
            rd[id]++;
         end else begin
            n_checks++;
            n_fail++;
            $display("FAIL valid[w=%0d] cyc=%0d: got unexpected strobe, expected none", w, cyc);
         end
      end else if (rd[id] < exp_q.size() && exp_q[rd[id]].cyc <= cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL valid[w=%0d] cyc=%0d: got %b expected 1", w, cyc, v);
         rd[id]++;
      end
   endtask

   always @(posedge clock) begin
      #1;
      check_out(0, valid32, longint'(cnt32), ovf32, busy32, 32);
      check_out(1, valid4,  longint'(cnt4),  ovf4,  busy4,  4);
   end

   // ---------------- stimulus helpers ----------------
   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " busy32"},  longint'(busy32),  0);
      chk({tag, " valid32"}, longint'(valid32), 0);
      chk({tag, " cnt32"},   longint'(cnt32),   0);
      chk({tag, " ovf32"},   longint'(ovf32),   0);
      chk({tag, " busy4"},   longint'(busy4),   0);
      chk({tag, " cnt4"},    longint'(cnt4),    0);
      chk({tag, " ovf4"},    longint'(ovf4),    0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k;
      k = 0;
      while ((busy32 || busy4 || rd[0] < exp_q.size() || rd[1] < exp_q.size()) && k < limit) begin
         @(negedge clock);
         k++;
      end
      if (k >= limit) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: got busy after %0d cycles, expected idle", k);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rd[0] = 0;
      rd[1] = 0;

      // reset held with sig_in toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk_cleared("reset_hold");
      end
      reset = 1'b0;

      // constant-low input
      gen_mode  = 0;
      gen_level = 1'b0;
      tick(3);
      pulse_start();
      wait_done(300);

      // period-10 square wave, phase sweep
      gen_mode   = 1;
      gen_period = 10;
      for (int ph = 0; ph < 10; ph++) begin
         gen_phase = ph;
         tick(5);
         pulse_start();
         wait_done(300);
      end

      // saturation on the 4-bit instance, then a normal window
      gen_period = 4;
      tick(5);
      pulse_start();
      wait_done(300);
      gen_period = 10;
      tick(5);
      pulse_start();
      wait_done(300);

      // start re-pulsed while busy is ignored
      pulse_start();
      tick(28);
      pulse_start();
      tick(67);
      pulse_start();
      wait_done(300);

      // reset mid-window
      tick(3);
      pulse_start();
      tick(49);
      reset = 1'b1;
      #1;
      chk_cleared("reset_mid");
      tick(2);
      reset = 1'b0;
      tick(3);
      pulse_start();
      wait_done(300);

      // continuous mode, dropped mid second window
      continuous = 1'b1;
      tick(2);
      pulse_start();
      tick(148);
      continuous = 1'b0;
      wait_done(400);

      // random traffic
      gen_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         start      = ($urandom_range(0, 29) == 0);
         continuous = ($urandom_range(0, 2) == 0);
         reset      = ($urandom_range(0, 399) == 0);
      end
      start      = 1'b0;
      continuous = 1'b0;
      reset      = 1'b0;
      wait_done(400);
      tick(3);

      n_checks++;
      if (rd[0] != exp_q.size() || rd[1] != exp_q.size()) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d consumed, expected %0d", rd[0], rd[1], exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
